// File: rtl/dcache_pkg.sv
// Shared types for the dcache access-port arbiter.
//   dc_req_t   : one complete dcache request (read/write enables, address, widths, write data)
//   dc_owner_e : which requester currently owns the dcache port (none, port 0 = LSU, port 1 = aux)
package dcache_pkg;

   typedef struct packed {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [2:0]  rwidth;
      logic        rsign;
      logic [2:0]  wwidth;
      logic [31:0] wdata;
   } dc_req_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } dc_owner_e;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// One requester port of the dcache arbiter.
//   req/ren/wen/addr/rwidth/rsign/wwidth/wdata : request from the master, held until gnt
//   gnt   : request accepted this cycle
//   resp  : completion, one cycle after gnt
//   rdata : read data, valid with resp for reads (0 otherwise)
// master = requester side, slave = arbiter side.
interface dcache_port_arbiter_if;

   logic        req;
   logic        ren;
   logic        wen;
   logic [31:0] addr;
   logic [2:0]  rwidth;
   logic        rsign;
   logic [2:0]  wwidth;
   logic [31:0] wdata;
   logic        gnt;
   logic        resp;
   logic [31:0] rdata;

   modport master (
      output req, ren, wen, addr, rwidth, rsign, wwidth, wdata,
      input  gnt, resp, rdata
   );

   modport slave (
      input  req, ren, wen, addr, rwidth, rsign, wwidth, wdata,
      output gnt, resp, rdata
   );

endinterface

// File: rtl/dcache_arb_pick.sv
// Combinational owner selection for the dcache port.
//   p0_req, p1_req : requests from the LSU (p0) and aux master (p1)
//   lock           : a stalled request holds the port
//   lock_owner     : owner of the stalled request
//   starve         : p1 has waited long enough to take priority
//   sel            : selected owner
module dcache_arb_pick
   import dcache_pkg::*;
(
   input  logic      p0_req,
   input  logic      p1_req,
   input  logic      lock,
   input  dc_owner_e lock_owner,
   input  logic      starve,
   output dc_owner_e sel
);

   always_comb begin
      sel = OWN_NONE;
      if (lock) begin
         // A stalled request keeps the port until the dcache accepts it.
         sel = lock_owner;
      end else if (starve && p1_req) begin
         sel = OWN_P1;
      end else if (p0_req) begin
         sel = OWN_P0;
      end else if (p1_req) begin
         sel = OWN_P1;
      end
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache access port between the pipeline LSU (p0) and an aux
// master such as debug/DMA (p1). One request is selected per cycle and driven to
// the dcache; a request the dcache cannot take (dc_valid=0) is held and locked
// until accepted. The completion (and read data) is routed back to the owner one
// cycle after the grant.
//   clk, rst        : clock, synchronous active-high reset
//   p0, p1          : requester ports (slave modport)
//   dc_*            : request fields to the dcache
//   dc_pipeline_en  : dcache capture enable
//   dc_valid        : dcache can take the currently driven request
//   dc_rdata        : dcache read data, valid the cycle after capture
module dcache_port_arbiter
   import dcache_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   dcache_port_arbiter_if.slave  p0,
   dcache_port_arbiter_if.slave  p1,
   output logic                  dc_ren,
   output logic                  dc_wen,
   output logic [31:0]           dc_addr,
   output logic [2:0]            dc_rwidth,
   output logic                  dc_rsign,
   output logic [2:0]            dc_wwidth,
   output logic [31:0]           dc_wdata,
   output logic                  dc_pipeline_en,
   input  logic                  dc_valid,
   input  logic [31:0]           dc_rdata
);

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   logic             lock_reg;
   dc_owner_e        lock_owner_reg;
   dc_owner_e        owner_reg;
   logic             resp_pending_reg;
   logic             was_read_reg;
   logic [CNT_W-1:0] starve_cnt_reg;

   dc_req_t   p0_fields;
   dc_req_t   p1_fields;
   dc_req_t   dc_req;
   dc_owner_e sel;
   logic      starve;
   logic      accept;
   logic      gnt0;
   logic      gnt1;
   logic      resp0;
   logic      resp1;

   assign p0_fields = {p0.ren, p0.wen, p0.addr, p0.rwidth, p0.rsign, p0.wwidth, p0.wdata};
   assign p1_fields = {p1.ren, p1.wen, p1.addr, p1.rwidth, p1.rsign, p1.wwidth, p1.wdata};

   assign starve = (starve_cnt_reg >= LIMIT_C);

   // Requests are masked during reset so every output reads 0 while rst is high.
   dcache_arb_pick u_pick (
      .p0_req     (p0.req && !rst),
      .p1_req     (p1.req && !rst),
      .lock       (lock_reg),
      .lock_owner (lock_owner_reg),
      .starve     (starve),
      .sel        (sel)
   );

   always_comb begin
      dc_req = '0;
      case (sel)
         OWN_P0:  dc_req = p0_fields;
         OWN_P1:  dc_req = p1_fields;
         default: dc_req = '0;
      endcase
   end

   assign dc_ren    = dc_req.ren;
   assign dc_wen    = dc_req.wen;
   assign dc_addr   = dc_req.addr;
   assign dc_rwidth = dc_req.rwidth;
   assign dc_rsign  = dc_req.rsign;
   assign dc_wwidth = dc_req.wwidth;
   assign dc_wdata  = dc_req.wdata;

   assign accept = (sel != OWN_NONE) && dc_valid;
   assign gnt0   = accept && (sel == OWN_P0);
   assign gnt1   = accept && (sel == OWN_P1);

   // With no request the dcache still captures (an idle ren=wen=0 slot);
   // only a stalled request freezes the dcache pipeline.
   assign dc_pipeline_en = !rst && ((sel == OWN_NONE) || dc_valid);

   assign resp0 = !rst && resp_pending_reg && (owner_reg == OWN_P0);
   assign resp1 = !rst && resp_pending_reg && (owner_reg == OWN_P1);

   assign p0.gnt   = gnt0;
   assign p1.gnt   = gnt1;
   assign p0.resp  = resp0;
   assign p1.resp  = resp1;
   assign p0.rdata = (resp0 && was_read_reg) ? dc_rdata : '0;
   assign p1.rdata = (resp1 && was_read_reg) ? dc_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_reg         <= 1'b0;
         lock_owner_reg   <= OWN_NONE;
         owner_reg        <= OWN_NONE;
         resp_pending_reg <= 1'b0;
         was_read_reg     <= 1'b0;
         starve_cnt_reg   <= '0;
      end else begin
         resp_pending_reg <= accept;
         owner_reg        <= accept ? sel : OWN_NONE;
         was_read_reg     <= accept && dc_req.ren;

         if ((sel != OWN_NONE) && !dc_valid) begin
            lock_reg       <= 1'b1;
            lock_owner_reg <= sel;
         end else if (accept) begin
            lock_reg       <= 1'b0;
            lock_owner_reg <= OWN_NONE;
         end

         if (p1.req && !gnt1) begin
            starve_cnt_reg <= starve ? LIMIT_C : starve_cnt_reg + CNT_W'(1);
         end else begin
            starve_cnt_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter. Stimulus pushes the expected
// completion (port, read data, cycle) into a scoreboard queue at each grant;
// a negedge monitor pops and compares whenever a port reports resp.
`timescale 1ns/1ps
module tb_dcache_port_arbiter;
   import dcache_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dc_ren, dc_wen, dc_rsign, dc_pipeline_en;
   logic [31:0] dc_addr, dc_wdata;
   logic [2:0]  dc_rwidth, dc_wwidth;
   logic        dc_valid;
   logic [31:0] dc_rdata;

   always #5 clk = ~clk;

   dcache_port_arbiter_if if_p0 ();
   dcache_port_arbiter_if if_p1 ();

   dcache_port_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .p0             (if_p0),
      .p1             (if_p1),
      .dc_ren         (dc_ren),
      .dc_wen         (dc_wen),
      .dc_addr        (dc_addr),
      .dc_rwidth      (dc_rwidth),
      .dc_rsign       (dc_rsign),
      .dc_wwidth      (dc_wwidth),
      .dc_wdata       (dc_wdata),
      .dc_pipeline_en (dc_pipeline_en),
      .dc_valid       (dc_valid),
      .dc_rdata       (dc_rdata)
   );

   typedef struct {
      int          port;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // dcache read data pattern driven in every cycle, so a response's data
   // identifies the cycle it was produced in.
   function automatic logic [31:0] pat(input int c);
      return {16'hD0D0, c[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, act, req, cyc);
      end else begin
         $display("ok   %s = %h (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      dc_rdata = pat(cyc);
   endtask

   task automatic drive(input int p, input logic req, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (p == 0) begin
         if_p0.req = req; if_p0.ren = ren; if_p0.wen = wen; if_p0.addr = addr;
         if_p0.rwidth = 3'd2; if_p0.rsign = 1'b0; if_p0.wwidth = 3'd2; if_p0.wdata = wdata;
      end else begin
         if_p1.req = req; if_p1.ren = ren; if_p1.wen = wen; if_p1.addr = addr;
         if_p1.rwidth = 3'd1; if_p1.rsign = 1'b1; if_p1.wwidth = 3'd0; if_p1.wdata = wdata;
      end
   endtask

   task automatic expect_resp(input int p, input logic [31:0] d);
      exp_t e;
      e.port  = p;
      e.rdata = d;
      e.cyc   = cyc + 1;
      sb.push_back(e);
   endtask

   // Both ports request every cycle: p0 wins 8 times, then p1 takes the 9th.
   // p0 stays pending through p1's grant and is granted right after.
   task automatic starve_run(input logic first_in_place);
      for (int i = 0; i < 9; i++) begin
         if (!(first_in_place && i == 0)) step();
         drive(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
         drive(1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
         #1;
         if (i < 8) begin
            chk($sformatf("starve_p0_gnt[%0d]", i), {31'd0, if_p0.gnt}, 32'd1);
            chk($sformatf("starve_p1_wait[%0d]", i), {31'd0, if_p1.gnt}, 32'd0);
            expect_resp(0, pat(cyc + 1));
         end else begin
            chk("starve_p1_gnt", {31'd0, if_p1.gnt}, 32'd1);
            chk("starve_p0_wait", {31'd0, if_p0.gnt}, 32'd0);
            chk("starve_dc_addr", dc_addr, 32'h300);
            chk("starve_dc_rsign", {31'd0, dc_rsign}, 32'd1);
            chk("starve_dc_rwidth", {29'd0, dc_rwidth}, 32'd1);
            expect_resp(1, pat(cyc + 1));
         end
      end
      step();
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("after_starve_p0_gnt", {31'd0, if_p0.gnt}, 32'd1);
      chk("after_starve_dc_addr", dc_addr, 32'h220);
      expect_resp(0, pat(cyc + 1));
      step();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Response monitor / scoreboard and request-protocol assertion.
   exp_t        mon_e;
   int          mon_p;
   logic [31:0] mon_d, mon_other;
   logic        p0_pend = 1'b0, p1_pend = 1'b0;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         failures++;
         $display("FAIL resp_missing: port=%0d got=no resp expected at cycle %0d (now %0d)",
                  sb[0].port, sb[0].cyc, cyc);
         sb.delete(0);
      end
      if (if_p0.resp || if_p1.resp) begin
         mon_p     = if_p0.resp ? 0 : 1;
         mon_d     = if_p0.resp ? if_p0.rdata : if_p1.rdata;
         mon_other = if_p0.resp ? if_p1.rdata : if_p0.rdata;
         checks++;
         if (if_p0.resp && if_p1.resp) begin
            failures++;
            $display("FAIL resp_both: got p0_resp=1 p1_resp=1 expected one port (cycle %0d)", cyc);
         end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected: got resp on port %0d expected none (cycle %0d)", mon_p, cyc);
         end else begin
            mon_e = sb[0];
            sb.delete(0);
            if (mon_e.port != mon_p || mon_e.cyc != cyc || mon_e.rdata !== mon_d || mon_other !== 32'h0) begin
               failures++;
               $display("FAIL resp: got port=%0d cyc=%0d rdata=%h other_rdata=%h expected port=%0d cyc=%0d rdata=%h other_rdata=0",
                        mon_p, cyc, mon_d, mon_other, mon_e.port, mon_e.cyc, mon_e.rdata);
            end else begin
               $display("ok   resp port=%0d rdata=%h (cycle %0d)", mon_p, mon_d, cyc);
            end
         end
      end
      if (!rst && ((p0_pend && !if_p0.req) || (p1_pend && !if_p1.req))) begin
         failures++;
         $display("FAIL protocol: got req dropped before gnt expected req held (cycle %0d)", cyc);
      end
      p0_pend = !rst && if_p0.req && !if_p0.gnt;
      p1_pend = !rst && if_p1.req && !if_p1.gnt;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      dc_valid = 1'b1;
      dc_rdata = 32'h0;
      drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
      drive(1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h77);
      rst = 1'b1;

      // Reset state: outputs zero even with requests present.
      step(); step();
      #1;
      chk("rst_p0_gnt", {31'd0, if_p0.gnt}, 32'd0);
      chk("rst_p1_gnt", {31'd0, if_p1.gnt}, 32'd0);
      chk("rst_pipeline_en", {31'd0, dc_pipeline_en}, 32'd0);
      chk("rst_dc_wen", {31'd0, dc_wen}, 32'd0);
      chk("rst_dc_addr", dc_addr, 32'h0);
      chk("rst_p0_resp", {31'd0, if_p0.resp}, 32'd0);
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;

      // Single p0 read.
      step();
      drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
      #1;
      chk("rd_p0_gnt", {31'd0, if_p0.gnt}, 32'd1);
      chk("rd_p1_gnt", {31'd0, if_p1.gnt}, 32'd0);
      chk("rd_dc_ren", {31'd0, dc_ren}, 32'd1);
      chk("rd_dc_addr", dc_addr, 32'h100);
      chk("rd_dc_rwidth", {29'd0, dc_rwidth}, 32'd2);
      chk("rd_pipeline_en", {31'd0, dc_pipeline_en}, 32'd1);
      expect_resp(0, 32'hDEADBEEF);

      // Response cycle, which is also an idle cycle.
      step();
      dc_rdata = 32'hDEADBEEF;
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("rd_p1_resp", {31'd0, if_p1.resp}, 32'd0);
      chk("idle_dc_ren", {31'd0, dc_ren}, 32'd0);
      chk("idle_dc_wen", {31'd0, dc_wen}, 32'd0);
      chk("idle_pipeline_en", {31'd0, dc_pipeline_en}, 32'd1);
      chk("idle_p0_gnt", {31'd0, if_p0.gnt}, 32'd0);
      step();
      #1;
      chk("idle_p0_resp", {31'd0, if_p0.resp}, 32'd0);

      // Back-to-back reads.
      for (int i = 0; i < 3; i++) begin
         step();
         drive(0, 1'b1, 1'b1, 1'b0, 32'(4 * i), 32'h0);
         #1;
         chk($sformatf("b2b_gnt[%0d]", i), {31'd0, if_p0.gnt}, 32'd1);
         chk($sformatf("b2b_addr[%0d]", i), dc_addr, 32'(4 * i));
         expect_resp(0, pat(cyc + 1));
      end
      step();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      starve_run(1'b0);

      // Stalled p1 write holds the port against a later p0 request.
      step();
      dc_valid = 1'b0;
      drive(1, 1'b1, 1'b0, 1'b1, 32'h2000, 32'h55);
      #1;
      chk("stall_p1_gnt0", {31'd0, if_p1.gnt}, 32'd0);
      chk("stall_dc_wen", {31'd0, dc_wen}, 32'd1);
      chk("stall_dc_addr0", dc_addr, 32'h2000);
      chk("stall_dc_wdata", dc_wdata, 32'h55);
      chk("stall_pipeline_en0", {31'd0, dc_pipeline_en}, 32'd0);
      step();
      drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      #1;
      chk("stall_p0_gnt1", {31'd0, if_p0.gnt}, 32'd0);
      chk("stall_p1_gnt1", {31'd0, if_p1.gnt}, 32'd0);
      chk("stall_dc_addr1", dc_addr, 32'h2000);
      chk("stall_pipeline_en1", {31'd0, dc_pipeline_en}, 32'd0);
      step();
      #1;
      chk("stall_dc_addr2", dc_addr, 32'h2000);
      chk("stall_p0_gnt2", {31'd0, if_p0.gnt}, 32'd0);
      step();
      dc_valid = 1'b1;
      #1;
      chk("stall_p1_accept", {31'd0, if_p1.gnt}, 32'd1);
      chk("stall_p0_gnt3", {31'd0, if_p0.gnt}, 32'd0);
      chk("stall_pipeline_en3", {31'd0, dc_pipeline_en}, 32'd1);
      expect_resp(1, 32'h0);
      step();
      drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("stall_p0_after", {31'd0, if_p0.gnt}, 32'd1);
      chk("stall_p0_addr", dc_addr, 32'h40);
      expect_resp(0, pat(cyc + 1));
      step();
      drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset right after an accept: pending response dropped, counter cleared.
      for (int i = 0; i < 5; i++) begin
         step();
         drive(0, 1'b1, 1'b1, 1'b0, 32'h500 + 32'(4 * i), 32'h0);
         drive(1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h77);
         #1;
         chk($sformatf("prerst_p0_gnt[%0d]", i), {31'd0, if_p0.gnt}, 32'd1);
         if (i < 4) expect_resp(0, pat(cyc + 1));
      end
      step();
      rst = 1'b1;
      #1;
      chk("midrst_p0_resp", {31'd0, if_p0.resp}, 32'd0);
      chk("midrst_p0_rdata", if_p0.rdata, 32'h0);
      chk("midrst_p0_gnt", {31'd0, if_p0.gnt}, 32'd0);
      chk("midrst_pipeline_en", {31'd0, dc_pipeline_en}, 32'd0);
      chk("midrst_dc_wen", {31'd0, dc_wen}, 32'd0);
      step();
      #1;
      chk("midrst2_p0_resp", {31'd0, if_p0.resp}, 32'd0);
      rst = 1'b0;
      starve_run(1'b1);

      repeat (3) step();
      #1;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
